// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage LEGv8 pipeline. It drives
// the write-enables, flushes and bubbles of the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It handles three cases:
//   - load-use stalls,
//   - variable-latency data-memory handshakes,
//   - taken-branch squashes (branches resolve in MEM).
//
// Optional build macro: STALL_COUNT_EN adds the stall_cycles output, which
// counts the cycles with pc_we=0 since reset and saturates at all-ones.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   id_ex_memread/rd        load in EX and its destination register
//   if_id_rn/rm             source registers of the instruction in ID
//   ex_mem_branch/uncbr     conditional / unconditional branch in MEM
//   ex_mem_zero             ALU zero flag in MEM
//   ex_mem_memrd/memwr      load / store in MEM
//   dmem_ready              data memory completes the access this cycle
//   dmem_req                data memory access request
//   pc_we, pc_src           PC write enable, 1 = load the branch target
//   if_id_we, if_id_flush   IF/ID enable, IF/ID loads a NOP
//   id_ex_bubble            ID/EX loads zeroed control
//   ex_mem_we, ex_mem_flush EX/MEM enable, EX/MEM loads zeroed control
//   mem_wb_bubble           MEM/WB loads zeroed control
//   state                   current FSM state (RUN=0 LDSTALL=1 MEMWAIT=2 FLUSH=3)
//   stall_cycles            (STALL_COUNT_EN only) stall cycle counter
//
// Handshake: dmem_req/dmem_ready follow valid/ready semantics. An access
// completes in the cycle where dmem_req and dmem_ready are both 1. While
// dmem_req=1 and dmem_ready=0, the whole pipe is frozen in that same cycle.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int ZERO_REG          = 31,
    parameter int CNT_W             = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rn,
    input  logic [4:0]       if_id_rm,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_uncbr,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_memrd,
    input  logic             ex_mem_memwr,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             pc_src,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
`ifdef STALL_COUNT_EN
    output logic [CNT_W-1:0] stall_cycles,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    localparam logic [4:0] ZERO_IDX  = 5'(ZERO_REG);
    // LDSTALL covers the stall cycles after the first one, which is taken in RUN.
    localparam logic [2:0] LD_EXTRA  = 3'(LOAD_STALL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] ld_cnt_q, ld_cnt_d;
    logic       live_q;

    logic dec_dmem_req, dec_pc_we, dec_pc_src, dec_if_id_we, dec_if_id_flush;
    logic dec_id_ex_bubble, dec_ex_mem_we, dec_ex_mem_flush, dec_mem_wb_bubble;
    logic taken, hazard, mem_pending;
    logic [2:0] ld_cnt_dec;

    assign taken      = ex_mem_uncbr | (ex_mem_branch & ex_mem_zero);
    assign hazard     = id_ex_memread & (id_ex_rd != ZERO_IDX) &
                        ((id_ex_rd == if_id_rn) | (id_ex_rd == if_id_rm));
    assign ld_cnt_dec = ld_cnt_q - 3'd1;

    // In MEMWAIT the request is held until it completes. In every other state
    // the request follows the access in MEM.
    assign dec_dmem_req = (state_q == ST_MEMWAIT) | ex_mem_memrd | ex_mem_memwr;
    assign mem_pending  = dec_dmem_req & ~dmem_ready;

    always_comb begin
        dec_pc_we         = 1'b1;
        dec_pc_src        = 1'b0;
        dec_if_id_we      = 1'b1;
        dec_if_id_flush   = 1'b0;
        dec_id_ex_bubble  = 1'b0;
        dec_ex_mem_we     = 1'b1;
        dec_ex_mem_flush  = 1'b0;
        dec_mem_wb_bubble = 1'b0;
        state_d           = ST_RUN;
        ld_cnt_d          = ld_cnt_q;

        if (!live_q) begin
            ld_cnt_d = 3'd0;
        end else if (mem_pending) begin
            // Freeze the whole pipe. A branch in MEM waits for the release cycle.
            dec_pc_we         = 1'b0;
            dec_if_id_we      = 1'b0;
            dec_ex_mem_we     = 1'b0;
            dec_mem_wb_bubble = 1'b1;
            state_d           = ST_MEMWAIT;
            ld_cnt_d          = 3'd0;
        end else if (taken) begin
            dec_pc_src       = 1'b1;
            dec_if_id_flush  = 1'b1;
            dec_id_ex_bubble = 1'b1;
            dec_ex_mem_flush = 1'b1;
            state_d          = ST_FLUSH;
            ld_cnt_d         = 3'd0;
        end else if (state_q == ST_LDSTALL) begin
            dec_pc_we        = 1'b0;
            dec_if_id_we     = 1'b0;
            dec_id_ex_bubble = 1'b1;
            ld_cnt_d         = ld_cnt_dec;
            state_d          = (ld_cnt_dec == 3'd0) ? ST_RUN : ST_LDSTALL;
        end else if (hazard && (state_q != ST_FLUSH)) begin
            // In FLUSH the EX instruction is a squashed wrong-path one.
            dec_pc_we        = 1'b0;
            dec_if_id_we     = 1'b0;
            dec_id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d  = ST_LDSTALL;
                ld_cnt_d = LD_EXTRA;
            end
        end
    end

    // live_q keeps every output at 0 from reset until the first edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            ld_cnt_q <= 3'd0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            live_q   <= 1'b1;
        end
    end

    assign dmem_req      = live_q & dec_dmem_req;
    assign pc_we         = live_q & dec_pc_we;
    assign pc_src        = live_q & dec_pc_src;
    assign if_id_we      = live_q & dec_if_id_we;
    assign if_id_flush   = live_q & dec_if_id_flush;
    assign id_ex_bubble  = live_q & dec_id_ex_bubble;
    assign ex_mem_we     = live_q & dec_ex_mem_we;
    assign ex_mem_flush  = live_q & dec_ex_mem_flush;
    assign mem_wb_bubble = live_q & dec_mem_wb_bubble;
    assign state         = state_q;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (live_q && !dec_pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_ex_memread;
    logic [4:0] id_ex_rd, if_id_rn, if_id_rm;
    logic       ex_mem_branch, ex_mem_uncbr, ex_mem_zero;
    logic       ex_mem_memrd, ex_mem_memwr, dmem_ready;

    logic       dmem_req, pc_we, pc_src, if_id_we, if_id_flush, id_ex_bubble;
    logic       ex_mem_we, ex_mem_flush, mem_wb_bubble;
    logic [1:0] state;

    logic       d3_dmem_req, d3_pc_we, d3_pc_src, d3_if_id_we, d3_if_id_flush;
    logic       d3_id_ex_bubble, d3_ex_mem_we, d3_ex_mem_flush, d3_mem_wb_bubble;
    logic [1:0] d3_state;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles, d3_stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pipeline_ctrl u_dut (
        .clock(clock), .reset_n(reset_n),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .if_id_rn(if_id_rn), .if_id_rm(if_id_rm),
        .ex_mem_branch(ex_mem_branch), .ex_mem_uncbr(ex_mem_uncbr),
        .ex_mem_zero(ex_mem_zero), .ex_mem_memrd(ex_mem_memrd),
        .ex_mem_memwr(ex_mem_memwr), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_we(pc_we), .pc_src(pc_src),
        .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
        .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
`ifdef STALL_COUNT_EN
        .stall_cycles(stall_cycles),
`endif
        .state(state)
    );

    pipeline_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .if_id_rn(if_id_rn), .if_id_rm(if_id_rm),
        .ex_mem_branch(ex_mem_branch), .ex_mem_uncbr(ex_mem_uncbr),
        .ex_mem_zero(ex_mem_zero), .ex_mem_memrd(ex_mem_memrd),
        .ex_mem_memwr(ex_mem_memwr), .dmem_ready(dmem_ready),
        .dmem_req(d3_dmem_req), .pc_we(d3_pc_we), .pc_src(d3_pc_src),
        .if_id_we(d3_if_id_we), .if_id_flush(d3_if_id_flush),
        .id_ex_bubble(d3_id_ex_bubble), .ex_mem_we(d3_ex_mem_we),
        .ex_mem_flush(d3_ex_mem_flush), .mem_wb_bubble(d3_mem_wb_bubble),
`ifdef STALL_COUNT_EN
        .stall_cycles(d3_stall_cycles),
`endif
        .state(d3_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        id_ex_memread = 1'b0; id_ex_rd = 5'd0; if_id_rn = 5'd0; if_id_rm = 5'd0;
        ex_mem_branch = 1'b0; ex_mem_uncbr = 1'b0; ex_mem_zero = 1'b0;
        ex_mem_memrd = 1'b0; ex_mem_memwr = 1'b0; dmem_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        ex_mem_memrd = 1'b1;

        // Reset: every output 0 even with a load in MEM.
        #12;
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_if_id_we", 32'(if_id_we), 32'd0);
        chk("rst_ex_mem_we", 32'(ex_mem_we), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        ex_mem_memrd = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_pc_we_before_edge", 32'(pc_we), 32'd0);

        // 1: ten idle cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("idle_pc_we", 32'(pc_we), 32'd1);
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_dmem_req", 32'(dmem_req), 32'd0);
        end
        chk("idle_ex_mem_we", 32'(ex_mem_we), 32'd1);
        chk("idle_mem_wb_bubble", 32'(mem_wb_bubble), 32'd0);

        // 2: load-use through rm.
        tick();
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rm = 5'd5;
        #1;
        chk("lu_pc_we", 32'(pc_we), 32'd0);
        chk("lu_if_id_we", 32'(if_id_we), 32'd0);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        chk("lu_ex_mem_we", 32'(ex_mem_we), 32'd1);
        chk("lu_state", 32'(state), 32'd0);
        chk("lu3_pc_we", 32'(d3_pc_we), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("lu_after_pc_we", 32'(pc_we), 32'd1);
        chk("lu_after_bubble", 32'(id_ex_bubble), 32'd0);
        chk("lu3_s1_state", 32'(d3_state), 32'd1);
        chk("lu3_s1_pc_we", 32'(d3_pc_we), 32'd0);
        chk("lu3_s1_bubble", 32'(d3_id_ex_bubble), 32'd1);
        tick();
        #1;
        chk("lu3_s2_state", 32'(d3_state), 32'd1);
        chk("lu3_s2_pc_we", 32'(d3_pc_we), 32'd0);
        tick();
        #1;
        chk("lu3_done_state", 32'(d3_state), 32'd0);
        chk("lu3_done_pc_we", 32'(d3_pc_we), 32'd1);

        // rd = XZR never stalls.
        id_ex_memread = 1'b1; id_ex_rd = 5'd31; if_id_rn = 5'd31; if_id_rm = 5'd31;
        #1;
        chk("xzr_pc_we", 32'(pc_we), 32'd1);
        chk("xzr_bubble", 32'(id_ex_bubble), 32'd0);
        chk("xzr3_pc_we", 32'(d3_pc_we), 32'd1);
        // Match through rn.
        id_ex_rd = 5'd7; if_id_rn = 5'd7; if_id_rm = 5'd0;
        #1;
        chk("lu_rn_pc_we", 32'(pc_we), 32'd0);
        // No memread, no stall.
        id_ex_memread = 1'b0;
        #1;
        chk("nomr_pc_we", 32'(pc_we), 32'd1);
        clear_inputs();
        tick();

        // 3: load with three MEMWAIT cycles.
        ex_mem_memrd = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("mw_req_dmem_req", 32'(dmem_req), 32'd1);
        chk("mw_req_pc_we", 32'(pc_we), 32'd0);
        chk("mw_req_ex_mem_we", 32'(ex_mem_we), 32'd0);
        chk("mw_req_mwb", 32'(mem_wb_bubble), 32'd1);
        chk("mw_req_state", 32'(state), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("mw_wait_state", 32'(state), 32'd2);
            chk("mw_wait_dmem_req", 32'(dmem_req), 32'd1);
            chk("mw_wait_pc_we", 32'(pc_we), 32'd0);
            chk("mw_wait_if_id_we", 32'(if_id_we), 32'd0);
        end
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("mw_rel_state", 32'(state), 32'd2);
        chk("mw_rel_ex_mem_we", 32'(ex_mem_we), 32'd1);
        chk("mw_rel_pc_we", 32'(pc_we), 32'd1);
        chk("mw_rel_mwb", 32'(mem_wb_bubble), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("mw_back_state", 32'(state), 32'd0);
        chk("mw_back_dmem_req", 32'(dmem_req), 32'd0);

        // Ready on the request cycle: no stall.
        ex_mem_memwr = 1'b1;
        #1;
        chk("mw_fast_dmem_req", 32'(dmem_req), 32'd1);
        chk("mw_fast_pc_we", 32'(pc_we), 32'd1);
        tick();
        clear_inputs();
        #1;
        chk("mw_fast_state", 32'(state), 32'd0);

        // 4: taken conditional branch, then FLUSH masks load-use.
        ex_mem_branch = 1'b1; ex_mem_zero = 1'b0;
        #1;
        chk("br_nt_pc_src", 32'(pc_src), 32'd0);
        ex_mem_zero = 1'b1;
        #1;
        chk("br_pc_src", 32'(pc_src), 32'd1);
        chk("br_pc_we", 32'(pc_we), 32'd1);
        chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("br_bubble", 32'(id_ex_bubble), 32'd1);
        chk("br_ex_mem_flush", 32'(ex_mem_flush), 32'd1);
        tick();
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rm = 5'd5;
        #1;
        chk("fl_state", 32'(state), 32'd3);
        chk("fl_pc_we", 32'(pc_we), 32'd1);
        chk("fl_bubble", 32'(id_ex_bubble), 32'd0);
        chk("fl_pc_src", 32'(pc_src), 32'd0);
        chk("fl3_pc_we", 32'(d3_pc_we), 32'd1);
        tick();
        clear_inputs();
        #1;
        chk("fl_back_state", 32'(state), 32'd0);

        // 5: store plus unconditional branch: memory first.
        ex_mem_memwr = 1'b1; ex_mem_uncbr = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("sb_req_pc_src", 32'(pc_src), 32'd0);
        chk("sb_req_pc_we", 32'(pc_we), 32'd0);
        chk("sb_req_flush", 32'(if_id_flush), 32'd0);
        tick();
        #1;
        chk("sb_wait_state", 32'(state), 32'd2);
        chk("sb_wait_pc_src", 32'(pc_src), 32'd0);
        dmem_ready = 1'b1;
        #1;
        chk("sb_rel_pc_src", 32'(pc_src), 32'd1);
        chk("sb_rel_pc_we", 32'(pc_we), 32'd1);
        chk("sb_rel_flush", 32'(ex_mem_flush), 32'd1);
        tick();
        clear_inputs();
        #1;
        chk("sb_fl_state", 32'(state), 32'd3);
        tick();
        #1;
        chk("sb_back_state", 32'(state), 32'd0);

        // 6: reset during MEMWAIT.
        ex_mem_memrd = 1'b1; dmem_ready = 1'b0;
        tick();
        #1;
        chk("rw_state", 32'(state), 32'd2);
        chk("rw_dmem_req", 32'(dmem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rw_async_dmem_req", 32'(dmem_req), 32'd0);
        chk("rw_async_state", 32'(state), 32'd0);
        chk("rw_async_pc_we", 32'(pc_we), 32'd0);
        clear_inputs();
        tick();
        reset_n = 1'b1;
        tick();
        #1;
        chk("rw_after_state", 32'(state), 32'd0);
        chk("rw_after_pc_we", 32'(pc_we), 32'd1);
`ifdef STALL_COUNT_EN
        chk("rw_stall_cycles", stall_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
